// File: rtl/cache_mem_arbiter.sv
// Shares one memory read port between icache and dcache (round-robin, one read
// outstanding) and buffers a single dcache write; reads to the buffered line stall.
module cache_mem_arbiter #(
    parameter int LINE_BYTES = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset,

    input  logic                    i_ic_rd_req,
    input  logic [2:0]              i_ic_rd_type,
    input  logic [31:0]             i_ic_rd_addr,
    output logic                    o_ic_rd_rdy,
    output logic                    o_ic_ret_valid,
    output logic                    o_ic_ret_last,
    output logic [31:0]             o_ic_ret_data,

    input  logic                    i_dc_rd_req,
    input  logic [2:0]              i_dc_rd_type,
    input  logic [31:0]             i_dc_rd_addr,
    output logic                    o_dc_rd_rdy,
    output logic                    o_dc_ret_valid,
    output logic                    o_dc_ret_last,
    output logic [31:0]             o_dc_ret_data,

    input  logic                    i_dc_wr_req,
    input  logic [2:0]              i_dc_wr_type,
    input  logic [31:0]             i_dc_wr_addr,
    input  logic [3:0]              i_dc_wr_wstrb,
    input  logic [LINE_BYTES*8-1:0] i_dc_wr_data,
    output logic                    o_dc_wr_rdy,

    output logic                    o_mem_rd_req,
    output logic [2:0]              o_mem_rd_type,
    output logic [31:0]             o_mem_rd_addr,
    input  logic                    i_mem_rd_rdy,
    input  logic                    i_mem_ret_valid,
    input  logic                    i_mem_ret_last,
    input  logic [31:0]             i_mem_ret_data,

    output logic                    o_mem_wr_req,
    output logic [2:0]              o_mem_wr_type,
    output logic [31:0]             o_mem_wr_addr,
    output logic [3:0]              o_mem_wr_wstrb,
    output logic [LINE_BYTES*8-1:0] o_mem_wr_data,
    input  logic                    i_mem_wr_rdy,
    input  logic                    i_mem_wr_done,

    output logic                    o_err
);
    localparam int LW    = LINE_BYTES * 8;
    localparam int BEATS = LINE_BYTES / 4;
    localparam int OFS   = $clog2(LINE_BYTES);
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) + 1 : 1;

    typedef enum logic [1:0] {R_IDLE, R_REQ, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_EMPTY, W_REQ, W_WAIT} wr_state_t;

    rd_state_t       r_rstate;
    wr_state_t       r_wstate;
    logic            r_owner;
    logic            r_last_grant;
    logic [CW-1:0]   r_beat_cnt;
    logic            r_mem_rd_req;
    logic [2:0]      r_mem_rd_type;
    logic [31:0]     r_mem_rd_addr;
    logic            r_dc_wr_rdy;
    logic            r_mem_wr_req;
    logic [2:0]      r_wr_type;
    logic [31:0]     r_wr_addr;
    logic [3:0]      r_wr_wstrb;
    logic [LW-1:0]   r_wr_data;
    logic            r_err;

    logic            w_wr_accept;
    logic            w_buf_valid;
    logic [1:0]      w_rd_req;
    logic [31:0]     w_rd_addr [2];
    logic [1:0]      w_haz;
    logic [1:0]      w_cand;
    logic [1:0]      w_grant;
    logic [CW-1:0]   w_last_idx;
    logic            w_fwd;

    assign w_wr_accept  = i_dc_wr_req && r_dc_wr_rdy;
    assign w_buf_valid  = (r_wstate != W_EMPTY);
    assign w_rd_req     = {i_dc_rd_req, i_ic_rd_req};
    assign w_rd_addr[0] = i_ic_rd_addr;
    assign w_rd_addr[1] = i_dc_rd_addr;

    // Index 0 is the icache, index 1 the dcache; the hazard also sees a write accepted this cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign w_haz[gi]  = (w_buf_valid && (w_rd_addr[gi][31:OFS] == r_wr_addr[31:OFS])) ||
                                (w_wr_accept && (w_rd_addr[gi][31:OFS] == i_dc_wr_addr[31:OFS]));
            assign w_cand[gi] = w_rd_req[gi] && !w_haz[gi];
        end
    endgenerate

    always_comb begin
        w_grant = 2'b00;
        if (r_rstate == R_IDLE) begin
            if (w_cand == 2'b11)
                w_grant = r_last_grant ? 2'b01 : 2'b10;
            else
                w_grant = w_cand;
        end
    end

    assign w_last_idx = (r_mem_rd_type == 3'b100) ? CW'(BEATS - 1) : '0;
    assign w_fwd      = (r_rstate == R_DATA);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rstate      <= R_IDLE;
            r_owner       <= 1'b0;
            r_last_grant  <= 1'b0;
            r_beat_cnt    <= '0;
            r_mem_rd_req  <= 1'b0;
            r_mem_rd_type <= 3'b000;
            r_mem_rd_addr <= 32'd0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (|w_grant) begin
                        r_owner       <= w_grant[1];
                        r_last_grant  <= w_grant[1];
                        r_mem_rd_type <= w_grant[1] ? i_dc_rd_type : i_ic_rd_type;
                        r_mem_rd_addr <= w_grant[1] ? i_dc_rd_addr : i_ic_rd_addr;
                        r_mem_rd_req  <= 1'b1;
                        r_beat_cnt    <= '0;
                        r_rstate      <= R_REQ;
                    end
                end
                R_REQ: begin
                    if (i_mem_rd_rdy) begin
                        r_mem_rd_req <= 1'b0;
                        r_rstate     <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (i_mem_ret_valid) begin
                        r_beat_cnt <= r_beat_cnt + CW'(1);
                        if (i_mem_ret_last)
                            r_rstate <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wstate     <= W_EMPTY;
            r_dc_wr_rdy  <= 1'b1;
            r_mem_wr_req <= 1'b0;
            r_wr_type    <= 3'b000;
            r_wr_addr    <= 32'd0;
            r_wr_wstrb   <= 4'd0;
            r_wr_data    <= '0;
        end else begin
            case (r_wstate)
                W_EMPTY: begin
                    if (i_dc_wr_req) begin
                        r_wr_type    <= i_dc_wr_type;
                        r_wr_addr    <= i_dc_wr_addr;
                        r_wr_wstrb   <= i_dc_wr_wstrb;
                        r_wr_data    <= i_dc_wr_data;
                        r_dc_wr_rdy  <= 1'b0;
                        r_mem_wr_req <= 1'b1;
                        r_wstate     <= W_REQ;
                    end
                end
                W_REQ: begin
                    if (i_mem_wr_rdy) begin
                        r_mem_wr_req <= 1'b0;
                        r_wstate     <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (i_mem_wr_done) begin
                        r_dc_wr_rdy <= 1'b1;
                        r_wstate    <= W_EMPTY;
                    end
                end
                default: r_wstate <= W_EMPTY;
            endcase
        end
    end

    // Sticky: short/long bursts, stray return beats, stray write completions.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_err <= 1'b0;
        end else if ((w_fwd && i_mem_ret_valid && i_mem_ret_last && (r_beat_cnt != w_last_idx)) ||
                     (!w_fwd && i_mem_ret_valid) ||
                     ((r_wstate != W_WAIT) && i_mem_wr_done)) begin
            r_err <= 1'b1;
        end
    end

    assign o_ic_rd_rdy    = w_grant[0];
    assign o_dc_rd_rdy    = w_grant[1];
    assign o_ic_ret_valid = w_fwd && !r_owner && i_mem_ret_valid;
    assign o_ic_ret_last  = w_fwd && !r_owner && i_mem_ret_last;
    assign o_ic_ret_data  = (w_fwd && !r_owner) ? i_mem_ret_data : 32'd0;
    assign o_dc_ret_valid = w_fwd && r_owner && i_mem_ret_valid;
    assign o_dc_ret_last  = w_fwd && r_owner && i_mem_ret_last;
    assign o_dc_ret_data  = (w_fwd && r_owner) ? i_mem_ret_data : 32'd0;
    assign o_dc_wr_rdy    = r_dc_wr_rdy;
    assign o_mem_rd_req   = r_mem_rd_req;
    assign o_mem_rd_type  = r_mem_rd_type;
    assign o_mem_rd_addr  = r_mem_rd_addr;
    assign o_mem_wr_req   = r_mem_wr_req;
    assign o_mem_wr_type  = r_wr_type;
    assign o_mem_wr_addr  = r_wr_addr;
    assign o_mem_wr_wstrb = r_wr_wstrb;
    assign o_mem_wr_data  = r_wr_data;
    assign o_err          = r_err;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed scoreboard bench for cache_mem_arbiter: stimulus pushes expectations,
// a negedge monitor pops them whenever the DUT presents a grant, handshake or beat.
module tb_cache_mem_arbiter;
    localparam int LB = 16;
    localparam int LW = LB * 8;
    localparam int VW = 276;
    localparam logic [VW-1:0] RST_V = {35'd0, 35'd0, 1'b1, 36'd0, 168'd0, 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ic_rd_req = 0, dc_rd_req = 0, dc_wr_req = 0;
    logic [2:0] ic_rd_type = 0, dc_rd_type = 0, dc_wr_type = 0;
    logic [31:0] ic_rd_addr = 0, dc_rd_addr = 0, dc_wr_addr = 0;
    logic [3:0] dc_wr_wstrb = 0;
    logic [LW-1:0] dc_wr_data = 0;
    logic mem_rd_rdy = 1, mem_ret_valid = 0, mem_ret_last = 0, mem_wr_rdy = 1, mem_wr_done = 0;
    logic [31:0] mem_ret_data = 0;

    logic o_ic_rd_rdy, o_ic_ret_valid, o_ic_ret_last, o_dc_rd_rdy, o_dc_ret_valid, o_dc_ret_last;
    logic [31:0] o_ic_ret_data, o_dc_ret_data, o_mem_rd_addr, o_mem_wr_addr;
    logic o_dc_wr_rdy, o_mem_rd_req, o_mem_wr_req, o_err;
    logic [2:0] o_mem_rd_type, o_mem_wr_type;
    logic [3:0] o_mem_wr_wstrb;
    logic [LW-1:0] o_mem_wr_data;

    cache_mem_arbiter #(.LINE_BYTES(LB)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_ic_rd_req(ic_rd_req), .i_ic_rd_type(ic_rd_type), .i_ic_rd_addr(ic_rd_addr),
        .o_ic_rd_rdy(o_ic_rd_rdy), .o_ic_ret_valid(o_ic_ret_valid), .o_ic_ret_last(o_ic_ret_last),
        .o_ic_ret_data(o_ic_ret_data),
        .i_dc_rd_req(dc_rd_req), .i_dc_rd_type(dc_rd_type), .i_dc_rd_addr(dc_rd_addr),
        .o_dc_rd_rdy(o_dc_rd_rdy), .o_dc_ret_valid(o_dc_ret_valid), .o_dc_ret_last(o_dc_ret_last),
        .o_dc_ret_data(o_dc_ret_data),
        .i_dc_wr_req(dc_wr_req), .i_dc_wr_type(dc_wr_type), .i_dc_wr_addr(dc_wr_addr),
        .i_dc_wr_wstrb(dc_wr_wstrb), .i_dc_wr_data(dc_wr_data), .o_dc_wr_rdy(o_dc_wr_rdy),
        .o_mem_rd_req(o_mem_rd_req), .o_mem_rd_type(o_mem_rd_type), .o_mem_rd_addr(o_mem_rd_addr),
        .i_mem_rd_rdy(mem_rd_rdy), .i_mem_ret_valid(mem_ret_valid), .i_mem_ret_last(mem_ret_last),
        .i_mem_ret_data(mem_ret_data),
        .o_mem_wr_req(o_mem_wr_req), .o_mem_wr_type(o_mem_wr_type), .o_mem_wr_addr(o_mem_wr_addr),
        .o_mem_wr_wstrb(o_mem_wr_wstrb), .o_mem_wr_data(o_mem_wr_data), .i_mem_wr_rdy(mem_wr_rdy),
        .i_mem_wr_done(mem_wr_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit            grant_q[$];
    logic [34:0]   mrd_q[$];
    logic [33:0]   beat_q[$];
    logic [166:0]  mwr_q[$];

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] outv();
        return {o_ic_rd_rdy, o_ic_ret_valid, o_ic_ret_last, o_ic_ret_data,
                o_dc_rd_rdy, o_dc_ret_valid, o_dc_ret_last, o_dc_ret_data,
                o_dc_wr_rdy, o_mem_rd_req, o_mem_rd_type, o_mem_rd_addr,
                o_mem_wr_req, o_mem_wr_type, o_mem_wr_addr, o_mem_wr_wstrb, o_mem_wr_data, o_err};
    endfunction

    function automatic logic [31:0] bdata(input logic [31:0] a, input int i);
        return a ^ {16'hA5C3, 8'h00, 8'(i)};
    endfunction

    function automatic logic [LW-1:0] wdata(input logic [31:0] a);
        return {a, ~a, a + 32'd1, 32'hDEADBEEF};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_read(input bit who, input logic [31:0] a, input logic [2:0] t);
        grant_q.push_back(who);
        mrd_q.push_back({t, a});
        if (who) begin
            dc_rd_req = 1; dc_rd_addr = a; dc_rd_type = t;
        end else begin
            ic_rd_req = 1; ic_rd_addr = a; ic_rd_type = t;
        end
    endtask

    task automatic start_write(input logic [31:0] a);
        dc_wr_req = 1; dc_wr_type = 3'b100; dc_wr_addr = a; dc_wr_wstrb = 4'hF; dc_wr_data = wdata(a);
        mwr_q.push_back({3'b100, a, 4'hF, wdata(a)});
    endtask

    // Expects the grant within max_wait extra cycles, then releases the request.
    task automatic wait_grant(input bit who, input int max_wait, input string name);
        bit seen = 0;
        for (int k = 0; k <= max_wait && !seen; k++) begin
            @(negedge clk);
            seen = who ? o_dc_rd_rdy : o_ic_rd_rdy;
        end
        check(name, seen, 1);
        tick();
        if (who) dc_rd_req = 0; else ic_rd_req = 0;
    endtask

    task automatic wait_memreq(input string name);
        @(negedge clk);
        check(name, o_mem_rd_req, 1);
    endtask

    task automatic send_beats(input bit who, input logic [31:0] a, input int n, input int last_idx);
        for (int i = 0; i < n; i++) begin
            tick();
            mem_ret_valid = 1;
            mem_ret_last  = (i == last_idx);
            mem_ret_data  = bdata(a, i);
            beat_q.push_back({who, (i == last_idx), bdata(a, i)});
        end
        tick();
        mem_ret_valid = 0; mem_ret_last = 0; mem_ret_data = 0;
    endtask

    bit          m_who;
    bit          m_exp_who;
    logic [33:0] m_beat;
    logic [33:0] m_exp_beat;
    logic [34:0] m_exp_rd;
    logic [166:0] m_exp_wr;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (o_ic_rd_rdy || o_dc_rd_rdy) begin
                m_who = o_dc_rd_rdy;
                check("grant_single", {o_ic_rd_rdy, o_dc_rd_rdy} != 2'b11, 1);
                check("grant_expected", grant_q.size() != 0, 1);
                if (grant_q.size() != 0) begin
                    m_exp_who = grant_q.pop_front();
                    check("grant_who", m_who, m_exp_who);
                end
                $display("[MON] grant to %s", m_who ? "dcache" : "icache");
            end
            if (o_mem_rd_req && mem_rd_rdy) begin
                check("mem_rd_expected", mrd_q.size() != 0, 1);
                if (mrd_q.size() != 0) begin
                    m_exp_rd = mrd_q.pop_front();
                    check("mem_rd_type_addr", {o_mem_rd_type, o_mem_rd_addr}, m_exp_rd);
                end
                $display("[MON] mem read type=%b addr=%h", o_mem_rd_type, o_mem_rd_addr);
            end
            if (o_ic_ret_valid || o_dc_ret_valid) begin
                check("ret_one_owner", {o_ic_ret_valid, o_dc_ret_valid} != 2'b11, 1);
                m_beat = o_dc_ret_valid ? {1'b1, o_dc_ret_last, o_dc_ret_data}
                                        : {1'b0, o_ic_ret_last, o_ic_ret_data};
                check("beat_expected", beat_q.size() != 0, 1);
                if (beat_q.size() != 0) begin
                    m_exp_beat = beat_q.pop_front();
                    check("ret_beat", m_beat, m_exp_beat);
                end
                $display("[MON] beat to %s last=%b data=%h", m_beat[33] ? "dcache" : "icache",
                         m_beat[32], m_beat[31:0]);
            end
            if (o_mem_wr_req && mem_wr_rdy) begin
                check("mem_wr_expected", mwr_q.size() != 0, 1);
                if (mwr_q.size() != 0) begin
                    m_exp_wr = mwr_q.pop_front();
                    check("mem_wr_fields", {o_mem_wr_type, o_mem_wr_addr, o_mem_wr_wstrb, o_mem_wr_data},
                          m_exp_wr);
                end
                $display("[MON] mem write addr=%h", o_mem_wr_addr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit blocked;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", outv(), RST_V);
        tick();
        rst = 0;

        // Single icache line read
        start_read(0, 32'h1C000100, 3'b100);
        wait_grant(0, 0, "t1_rdy_cycle0");
        wait_memreq("t1_memreq_cycle1");
        send_beats(0, 32'h1C000100, 4, 3);

        // Simultaneous requests, twice: dcache, icache, dcache, icache
        for (int r = 0; r < 2; r++) begin
            start_read(1, 32'h00010000 + 32'(r) * 32'h100, 3'b100);
            start_read(0, 32'h00020000 + 32'(r) * 32'h100, 3'b010);
            wait_grant(1, 0, "rr_dc_first");
            wait_memreq("rr_dc_memreq");
            send_beats(1, 32'h00010000 + 32'(r) * 32'h100, 4, 3);
            wait_grant(0, 0, "rr_ic_next");
            wait_memreq("rr_ic_memreq");
            send_beats(0, 32'h00020000 + 32'(r) * 32'h100, 1, 0);
        end

        // Writeback then read of the same line: stalled until mem_wr_done
        start_write(32'h00002000);
        @(negedge clk);
        check("hz_wr_accept", o_dc_wr_rdy, 1);
        tick();
        dc_wr_req = 0;
        start_read(1, 32'h00002004, 3'b010);
        @(negedge clk);
        check("hz_mem_wr_req_t1", o_mem_wr_req, 1);
        blocked = o_dc_rd_rdy;
        repeat (4) begin
            tick();
            @(negedge clk);
            blocked |= o_dc_rd_rdy;
        end
        tick();
        mem_wr_done = 1;
        @(negedge clk);
        blocked |= o_dc_rd_rdy;
        check("hz_blocked", blocked, 0);
        tick();
        mem_wr_done = 0;
        wait_grant(1, 0, "hz_rdy_after_done");
        check("hz_wr_rdy_back", o_dc_wr_rdy, 1);
        wait_memreq("hz_memreq");
        send_beats(1, 32'h00002004, 1, 0);

        // Write to line 0x3000 accepted with a read of line 0x4000
        start_write(32'h00003000);
        start_read(1, 32'h00004000, 3'b100);
        @(negedge clk);
        check("sc_rd_granted", o_dc_rd_rdy, 1);
        check("sc_wr_accept", o_dc_wr_rdy, 1);
        tick();
        dc_wr_req = 0;
        dc_rd_req = 0;
        @(negedge clk);
        check("sc_both_req", {o_mem_rd_req, o_mem_wr_req}, 2'b11);
        send_beats(1, 32'h00004000, 4, 3);
        mem_wr_done = 1;
        tick();
        mem_wr_done = 0;
        @(negedge clk);
        check("sc_wr_rdy_back", o_dc_wr_rdy, 1);
        check("sc_no_err", o_err, 0);

        // Short burst: ret_last on beat 2 of a line read
        tick();
        start_read(0, 32'h1C000200, 3'b100);
        wait_grant(0, 0, "er_grant");
        wait_memreq("er_memreq");
        send_beats(0, 32'h1C000200, 2, 1);
        @(negedge clk);
        check("er_set", o_err, 1);
        tick();
        start_read(0, 32'h1C000300, 3'b010);
        wait_grant(0, 0, "er_back_to_idle");
        wait_memreq("er_memreq2");
        send_beats(0, 32'h1C000300, 1, 0);
        @(negedge clk);
        check("er_sticky", o_err, 1);

        // Reset while the read is in R_DATA and the write in W_WAIT
        tick();
        start_write(32'h00005000);
        start_read(0, 32'h00006000, 3'b100);
        wait_grant(0, 0, "rs_grant");
        dc_wr_req = 0;
        wait_memreq("rs_memreq");
        send_beats(0, 32'h00006000, 1, 99);
        rst = 1;
        @(negedge clk);
        check("rs_outputs", outv(), RST_V);
        tick();
        rst = 0;
        start_read(1, 32'h00007000, 3'b010);
        wait_grant(1, 0, "rs_regrant");
        wait_memreq("rs_memreq2");
        send_beats(1, 32'h00007000, 1, 0);
        @(negedge clk);
        check("rs_err_clear", o_err, 0);

        repeat (3) tick();
        check("sb_drained", grant_q.size() + mrd_q.size() + beat_q.size() + mwr_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
